rv_id_ctrl: RTL

RV_ID_CTRL -- requirements
Module: rv_id_ctrl

---
 rtl/rv_pkg.sv | 42 ++++
 rtl/rv_id_ctrl_if.sv | 29 ++
 rtl/rv_imm_gen.sv | 22 ++
 rtl/rv_id_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared decode-stage constants: opcodes, FSM encoding, latency range and payload types.
package rv_pkg;

   localparam int unsigned XLEN         = 64;
   localparam int unsigned ILEN         = 32;
   localparam int unsigned LOAD_LAT_MIN = 1;
   localparam int unsigned LOAD_LAT_MAX = 3;
   localparam int unsigned LAT_CNT_W    = 2;
   localparam int unsigned STALL_CNT_W  = 32;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HOLD  = 2'd1,
      ST_STALL = 2'd2
   } id_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } id_word_t;

   function automatic logic reads_rs1(input logic [6:0] opc);
      return opc inside {OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OP_IMM,
                         OPC_OP, OPC_JALR, OPC_OP_IMM_32, OPC_OP_32};
   endfunction

   function automatic logic reads_rs2(input logic [6:0] opc);
      return opc inside {OPC_STORE, OPC_BRANCH, OPC_OP, OPC_OP_32};
   endfunction

endpackage

// File: rtl/rv_id_ctrl_if.sv
// Fetch/decode/EX handshake bundle; names are from the decode controller's point of view.
interface rv_id_ctrl_if;
   import rv_pkg::*;

   logic            if_valid_i;
   logic [ILEN-1:0] if_instr_i;
   logic [XLEN-1:0] if_pc_i;
   logic            id_ready_o;
   logic            id_valid_o;
   logic            ex_ready_i;
   logic [ILEN-1:0] id_instr_o;
   logic [XLEN-1:0] id_pc_o;
   logic [XLEN-1:0] id_imm_o;
   logic            ex_is_load_i;
   logic [4:0]      ex_rd_i;
   logic            flush_i;
   logic [STALL_CNT_W-1:0] stall_cnt_o;

   modport master (
      output if_valid_i, if_instr_i, if_pc_i, ex_ready_i, ex_is_load_i, ex_rd_i, flush_i,
      input  id_ready_o, id_valid_o, id_instr_o, id_pc_o, id_imm_o, stall_cnt_o
   );

   modport slave (
      input  if_valid_i, if_instr_i, if_pc_i, ex_ready_i, ex_is_load_i, ex_rd_i, flush_i,
      output id_ready_o, id_valid_o, id_instr_o, id_pc_o, id_imm_o, stall_cnt_o
   );

endinterface

// File: rtl/rv_imm_gen.sv
// Sign-extended immediate for load/store/branch/upper formats; zero for everything else.
module rv_imm_gen
   import rv_pkg::*;
(
   input  logic [ILEN-1:0] instr_i,
   output logic [XLEN-1:0] imm_o
);

   always_comb begin
      imm_o = '0;
      case (instr_i[6:0])
         OPC_LOAD:   imm_o = {{52{instr_i[31]}}, instr_i[31:20]};
         OPC_STORE:  imm_o = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         OPC_BRANCH: imm_o = {{51{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
         OPC_LUI,
         OPC_AUIPC:  imm_o = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
         default:    imm_o = '0;
      endcase
   end

endmodule

// File: rtl/rv_id_ctrl.sv
// Decode-stage hold register with load-use bubble insertion, flush and bubble counter.
module rv_id_ctrl
   import rv_pkg::*;
#(
   parameter int unsigned LOAD_LAT = 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   rv_id_ctrl_if.slave   bus
);

   localparam logic [LAT_CNT_W-1:0] LAT_RELOAD = LAT_CNT_W'(LOAD_LAT - 1);

   id_state_e              state_q, state_d;
   id_word_t               hold_q, hold_d;
   logic [LAT_CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
   logic                   served_q, served_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic                   hazard_c;
   logic                   fetch_xfer;
   logic                   bubble;

   logic [6:0] opc;
   logic [4:0] rs1, rs2;

   assign opc = hold_q.instr[6:0];
   assign rs1 = hold_q.instr[19:15];
   assign rs2 = hold_q.instr[24:20];

   // served_q masks the hazard once its bubbles have been paid for this instruction
   assign hazard_c = bus.ex_is_load_i && (bus.ex_rd_i != 5'd0) && !served_q &&
                     ((reads_rs1(opc) && (bus.ex_rd_i == rs1)) ||
                      (reads_rs2(opc) && (bus.ex_rd_i == rs2)));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_EMPTY;
         hold_q      <= '0;
         lat_cnt_q   <= '0;
         served_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         lat_cnt_q   <= lat_cnt_d;
         served_q    <= served_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      hold_d         = hold_q;
      lat_cnt_d      = lat_cnt_q;
      served_d       = served_q;
      stall_cnt_d    = stall_cnt_q;
      bus.id_valid_o = 1'b0;
      bus.id_ready_o = 1'b0;
      fetch_xfer     = 1'b0;
      bubble         = 1'b0;

      if (bus.flush_i) begin
         bus.id_ready_o = 1'b1;
         state_d        = ST_EMPTY;
         lat_cnt_d      = '0;
         served_d       = 1'b0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               bus.id_ready_o = 1'b1;
               fetch_xfer     = bus.if_valid_i;
            end
            ST_HOLD: begin
               if (hazard_c) begin
                  bubble    = 1'b1;
                  served_d  = 1'b1;
                  lat_cnt_d = LAT_RELOAD;
                  // the hazard cycle is itself the first bubble
                  if (LOAD_LAT > 1) state_d = ST_STALL;
               end else begin
                  bus.id_valid_o = 1'b1;
                  bus.id_ready_o = bus.ex_ready_i;
                  fetch_xfer     = bus.if_valid_i && bus.ex_ready_i;
                  if (bus.ex_ready_i && !fetch_xfer) state_d = ST_EMPTY;
               end
            end
            ST_STALL: begin
               bubble = 1'b1;
               if (lat_cnt_q <= LAT_CNT_W'(1)) begin
                  state_d   = ST_HOLD;
                  lat_cnt_d = '0;
               end else begin
                  lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
               end
            end
            default: state_d = ST_EMPTY;
         endcase

         if (fetch_xfer) begin
            hold_d   = '{pc: bus.if_pc_i, instr: bus.if_instr_i};
            state_d  = ST_HOLD;
            served_d = 1'b0;
         end

         if (bubble && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   assign bus.id_instr_o  = hold_q.instr;
   assign bus.id_pc_o     = hold_q.pc;
   assign bus.stall_cnt_o = stall_cnt_q;

   rv_imm_gen u_imm_gen (
      .instr_i (hold_q.instr),
      .imm_o   (bus.id_imm_o)
   );

endmodule
